// File: rtl/rect_fill_gpu_if.sv
// Command and framebuffer write-port bundle for the rectangle fill engine.
// master = command source / write-port sink, slave = the fill engine.
interface rect_fill_gpu_if #(
  parameter int ADDR_W  = 19,
  parameter int COLOR_W = 6
);
  logic               start;
  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_clear;
  logic [9:0]         cmd_x0;
  logic [9:0]         cmd_y0;
  logic [9:0]         cmd_x1;
  logic [9:0]         cmd_y1;
  logic [COLOR_W-1:0] cmd_color;
  logic [ADDR_W-1:0]  addr;
  logic [COLOR_W-1:0] dout;
  logic               wen;
  logic               busy;
  logic               done;
  logic               err;

  modport master (
    output start, cmd_valid, cmd_clear, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color,
    input  cmd_ready, addr, dout, wen, busy, done, err
  );

  modport slave (
    input  start, cmd_valid, cmd_clear, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color,
    output cmd_ready, addr, dout, wen, busy, done, err
  );
endinterface

// File: rtl/rect_fill_gpu.sv
// Rectangle-fill / clear engine driving the framebuffer write port, one pixel
// per clock in raster order at linear address H_RES*y + x.
module rect_fill_gpu #(
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int ADDR_W  = 19,
  parameter int COLOR_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  rect_fill_gpu_if.slave  bus
);

  localparam int                CW     = 10;
  localparam logic [CW-1:0]     X_LAST = CW'(H_RES - 1);
  localparam logic [CW-1:0]     Y_LAST = CW'(V_RES - 1);
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(H_RES);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_FILL, S_DONE} state_t;

  state_t             r_state;
  logic [CW-1:0]      r_x0, r_y0, r_x1, r_y1, r_x, r_y;
  logic [COLOR_W-1:0] r_color, r_dout;
  logic [ADDR_W-1:0]  r_row_base, r_addr;
  logic               r_wen, r_done, r_err, r_last;

  logic [CW-1:0]      w_x1c, w_y1c, w_cx, w_cy;
  logic [ADDR_W-1:0]  w_base0, w_cbase;
  logic               w_reject, w_in_setup, w_row_end, w_final, w_step;

  assign w_x1c    = (r_x1 > X_LAST) ? X_LAST : r_x1;
  assign w_y1c    = (r_y1 > Y_LAST) ? Y_LAST : r_y1;
  assign w_reject = (r_x0 > X_LAST) || (r_y0 > Y_LAST) || (r_x0 > w_x1c) || (r_y0 > w_y1c);
  assign w_base0  = ADDR_W'(r_y0) * STRIDE;

  // The first pixel is issued straight out of SETUP, so the "current position"
  // comes from the latched corner there and from the walking registers in FILL.
  assign w_in_setup = (r_state == S_SETUP);
  assign w_cx       = w_in_setup ? r_x0    : r_x;
  assign w_cy       = w_in_setup ? r_y0    : r_y;
  assign w_cbase    = w_in_setup ? w_base0 : r_row_base;
  assign w_row_end  = (w_cx == w_x1c);
  assign w_final    = w_row_end && (w_cy == w_y1c);
  assign w_step     = (w_in_setup && !w_reject) || (r_state == S_FILL && !r_last);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_dout  <= '0;
      r_wen   <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      r_wen  <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            r_x0    <= bus.cmd_clear ? '0     : bus.cmd_x0;
            r_y0    <= bus.cmd_clear ? '0     : bus.cmd_y0;
            r_x1    <= bus.cmd_clear ? X_LAST : bus.cmd_x1;
            r_y1    <= bus.cmd_clear ? Y_LAST : bus.cmd_y1;
            r_color <= bus.cmd_color;
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_last <= 1'b0;
          if (w_reject) begin
            r_done  <= 1'b1;
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_state <= S_FILL;
          end
        end
        S_FILL: begin
          if (r_last) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase

      // Incremental row walk: row_base advances by the stride, never multiplied.
      if (w_step) begin
        if (bus.start) begin
          r_wen  <= 1'b1;
          r_addr <= w_cbase + ADDR_W'(w_cx);
          r_dout <= r_color;
          r_last <= w_final;
          if (w_row_end) begin
            r_x        <= r_x0;
            r_y        <= w_cy + 10'd1;
            r_row_base <= w_cbase + STRIDE;
          end else begin
            r_x        <= w_cx + 10'd1;
            r_y        <= w_cy;
            r_row_base <= w_cbase;
          end
        end else begin
          r_x        <= w_cx;
          r_y        <= w_cy;
          r_row_base <= w_cbase;
        end
      end
    end
  end

  assign bus.cmd_ready = (r_state == S_IDLE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.addr      = r_addr;
  assign bus.dout      = r_dout;
  assign bus.wen       = r_wen;
  assign bus.done      = r_done;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_rect_fill_gpu.sv
// Bench for rect_fill_gpu: table of fill commands with a write scoreboard,
// plus hand-written reset, clear and stall sequences.
module tb_rect_fill_gpu;
  localparam int H  = 640;
  localparam int V  = 480;
  localparam int AW = 19;
  localparam int CD = 6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rect_fill_gpu_if #(.ADDR_W(AW), .COLOR_W(CD)) bus();
  rect_fill_gpu #(.H_RES(H), .V_RES(V), .ADDR_W(AW), .COLOR_W(CD)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [CD-1:0] dout;
  } wr_t;

  typedef struct {
    string         name;
    logic          clr;
    int            x0, y0, x1, y1;
    logic [CD-1:0] col;
    logic          exp_err;
    int            exp_n;
    int            exp_last;
  } vec_t;

  wr_t  q[$];
  vec_t vt[7];

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_wr = 0;
  int n_done = 0;
  int first_wen = -1;
  int last_wen = -1;
  logic [AW-1:0] last_addr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Write monitor / scoreboard consumer.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) n_done++;
      if (bus.wen === 1'b1) begin
        n_wr++;
        if (first_wen < 0) first_wen = cyc;
        last_wen  = cyc;
        last_addr = bus.addr;
        if (q.size() == 0) begin
          check("unexpected_write", 32'(bus.addr), 32'hFFFF_FFFF);
        end else begin
          e = q.pop_front();
          check("wr_addr", 32'(bus.addr), 32'(e.addr));
          check("wr_dout", 32'(bus.dout), 32'(e.dout));
        end
      end
    end
  end

  task automatic push_rect(input logic clr, input int x0, input int y0, input int x1,
                           input int y1, input logic [CD-1:0] col);
    wr_t w;
    int  cx1, cy1;
    if (clr) begin
      x0 = 0; y0 = 0; x1 = H - 1; y1 = V - 1;
    end
    cx1 = (x1 > H - 1) ? H - 1 : x1;
    cy1 = (y1 > V - 1) ? V - 1 : y1;
    if (x0 >= H || y0 >= V || x0 > cx1 || y0 > cy1) return;
    for (int y = y0; y <= cy1; y++)
      for (int x = x0; x <= cx1; x++) begin
        w.addr = AW'(y * H + x);
        w.dout = col;
        q.push_back(w);
      end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    q.delete();
  endtask

  task automatic run_vec(input vec_t v);
    int   s, d, n0, nd0;
    bit   got;
    logic e;
    @(negedge clk);
    check({v.name, "_ready"}, 32'(bus.cmd_ready), 32'd1);
    push_rect(v.clr, v.x0, v.y0, v.x1, v.y1, v.col);
    bus.cmd_clear = v.clr;
    bus.cmd_x0    = 10'(v.x0);
    bus.cmd_y0    = 10'(v.y0);
    bus.cmd_x1    = 10'(v.x1);
    bus.cmd_y1    = 10'(v.y1);
    bus.cmd_color = v.col;
    bus.cmd_valid = 1'b1;
    bus.start     = 1'b1;
    first_wen = -1;
    n0  = n_wr;
    nd0 = n_done;
    @(negedge clk);
    s = cyc;
    // Scramble the fields and keep valid high while busy: both must be ignored.
    bus.cmd_x0 = 10'd0; bus.cmd_y0 = 10'd0; bus.cmd_x1 = 10'd1; bus.cmd_y1 = 10'd1;
    bus.cmd_color = '0;
    got = 1'b0;
    e   = 1'b0;
    d   = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        got = 1'b1;
        d   = cyc;
        e   = bus.err;
        break;
      end
    end
    bus.cmd_valid = 1'b0;
    #1;
    check({v.name, "_done_seen"}, 32'(got), 32'd1);
    if (!got) pulse_reset();
    check({v.name, "_err"}, 32'(e), 32'(v.exp_err));
    check({v.name, "_nwrites"}, 32'(n_wr - n0), 32'(v.exp_n));
    check({v.name, "_done_count"}, 32'(n_done - nd0), 32'd1);
    if (v.exp_n > 0) begin
      check({v.name, "_first_wen_lat"}, 32'(first_wen), 32'(s + 1));
      check({v.name, "_done_after_last"}, 32'(d), 32'(last_wen + 1));
      check({v.name, "_last_addr"}, 32'(last_addr), 32'(v.exp_last));
    end else begin
      check({v.name, "_rej_done_lat"}, 32'(d), 32'(s + 1));
    end
    check({v.name, "_sb_empty"}, 32'(q.size()), 32'd0);
    @(negedge clk);
    check({v.name, "_done_1cyc"}, 32'(bus.done), 32'd0);
    check({v.name, "_idle_busy"}, 32'(bus.busy), 32'd0);
    check({v.name, "_idle_ready"}, 32'(bus.cmd_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1);
  end

  initial begin
    int          n0, nd0, held;
    bit          ok;
    wr_t         w;

    vt[0] = '{"pixel",   1'b0,   5,   2,    5,   2, 6'h30, 1'b0,   1,   1285};
    vt[1] = '{"rect3x2", 1'b0,  10,   5,   12,   6, 6'h0F, 1'b0,   6,   3852};
    vt[2] = '{"clamp",   1'b0, 630, 470, 1000, 900, 6'h15, 1'b0, 100, 307199};
    vt[3] = '{"rej_x",   1'b0,  20,   0,   10,   0, 6'h01, 1'b1,   0,      0};
    vt[4] = '{"rej_x0",  1'b0, 700,   0,  710,   5, 6'h02, 1'b1,   0,      0};
    vt[5] = '{"rej_y",   1'b0,   0,   9,    5,   3, 6'h03, 1'b1,   0,      0};
    vt[6] = '{"wrap",    1'b0, 638,   3,  639,   4, 6'h2A, 1'b0,   4,   3199};

    reset = 1'b1;
    bus.start = 1'b0; bus.cmd_valid = 1'b0; bus.cmd_clear = 1'b0;
    bus.cmd_x0 = '0; bus.cmd_y0 = '0; bus.cmd_x1 = '0; bus.cmd_y1 = '0; bus.cmd_color = '0;
    repeat (3) @(negedge clk);
    check("rst_addr", 32'(bus.addr), 32'd0);
    check("rst_dout", 32'(bus.dout), 32'd0);
    check("rst_wen",  32'(bus.wen),  32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_err",  32'(bus.err),  32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(bus.cmd_ready), 32'd1);

    // Clear with garbage coordinates, stall mid-fill, then reset mid-fill.
    for (int i = 0; i < 3000; i++) begin
      w.addr = AW'(i);
      w.dout = 6'h3F;
      q.push_back(w);
    end
    bus.cmd_clear = 1'b1; bus.cmd_x0 = 10'd900; bus.cmd_y0 = 10'd1000;
    bus.cmd_x1 = 10'd3; bus.cmd_y1 = 10'd2; bus.cmd_color = 6'h3F;
    bus.cmd_valid = 1'b1; bus.start = 1'b1;
    n0  = n_wr;
    nd0 = n_done;
    @(negedge clk);
    bus.cmd_valid = 1'b0; bus.cmd_clear = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (n_wr - n0 >= 1000) begin ok = 1'b1; break; end
    end
    check("clr_progress1", 32'(ok), 32'd1);
    bus.start = 1'b0;
    held = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      if (i == 0) begin
        held = n_wr - n0 - 1;
        check("stall_pos", 32'(bus.addr), 32'(held));
      end else begin
        check("stall_addr_hold", 32'(bus.addr), 32'(held));
      end
      check("stall_wen", 32'(bus.wen), 32'd0);
    end
    bus.start = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (n_wr - n0 >= 2000) begin ok = 1'b1; break; end
    end
    check("clr_progress2", 32'(ok), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("midrst_wen",   32'(bus.wen),       32'd0);
    check("midrst_busy",  32'(bus.busy),      32'd0);
    check("midrst_ready", 32'(bus.cmd_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      check("postrst_wen",  32'(bus.wen),  32'd0);
      check("postrst_busy", 32'(bus.busy), 32'd0);
    end
    check("midrst_no_done", 32'(n_done - nd0), 32'd0);
    q.delete();

    for (int i = 0; i < 7; i++) run_vec(vt[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/rect_fill_gpu.md
Name: rect_fill_gpu

Overview:
Framebuffer write engine that feeds the dual-port block-RAM framebuffer's write port (port A: addr/din/we) in the VGA display path.
Accepts rectangle-fill commands over a valid/ready handshake and emits one pixel write per clock in raster order, using the framebuffer's linear address 640*y + x.
Also supports a full-screen clear.
Sits directly upstream of the framebuffer; the VGA scan-out reads port B independently.

Parameters:
H_RES, 640, horizontal pixels; also the row stride of the framebuffer.
V_RES, 480, vertical lines.
ADDR_W, 19, framebuffer address width.
COLOR_W, 6, pixel width (RRGGBB, 2 bits each).

Ports:
clk  input  1  system clock; the framebuffer and VGA pixel logic share this clock.
reset  input  1  synchronous, active-high reset.
start  input  1  run enable; while 0 in FILL, the engine stalls.
cmd_valid  input  1  command present.
cmd_ready  output  1  engine can accept a command; high only in IDLE.
cmd_clear  input  1  1 = fill the whole screen with cmd_color; the coordinates are ignored.
cmd_x0  input  10  left column, inclusive.
cmd_y0  input  10  top row, inclusive.
cmd_x1  input  10  right column, inclusive.
cmd_y1  input  10  bottom row, inclusive.
cmd_color  input  COLOR_W  fill colour.
addr  output  ADDR_W  framebuffer write address.
dout  output  COLOR_W  framebuffer write data.
wen  output  1  framebuffer write enable.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle pulse when a command finishes, including a rejected command.
err  output  1  one-cycle pulse, coincident with done, when a command is rejected.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE, addr=0, dout=0, wen=0, busy=0, done=0, err=0. cmd_ready=1 in the first cycle after reset.
- Reset mid-operation: the engine returns to IDLE at the next edge. wen=0 from that cycle on. The command is dropped and no done pulse is issued.
- Handshake: a command is accepted on a rising edge with cmd_valid=1 and cmd_ready=1. All cmd_* fields are latched at that edge; later changes are ignored. cmd_valid while busy is ignored and not queued.
- State machine:
  - IDLE -> SETUP on accept.
  - SETUP (1 cycle):
    - Clamp x1 to min(x1, H_RES-1) and y1 to min(y1, V_RES-1).
    - Reject the command if x0 >= H_RES, y0 >= V_RES, x0 > clamped x1, or y0 > clamped y1; go to DONE with err=1.
    - Otherwise compute row_base = y0*H_RES (constant multiply, this cycle only) and go to FILL.
    - cmd_clear forces x0=0, y0=0, x1=H_RES-1, y1=V_RES-1 and is never rejected.
  - FILL:
    - Each cycle with start=1: wen=1, addr=row_base+x, dout=latched colour.
    - Advance x. At x == x1, set x=x0, y=y+1, row_base=row_base+H_RES.
    - After writing (x1,y1), go to DONE.
    - With start=0: wen=0, and position and addr hold.
  - DONE (1 cycle): done=1, wen=0; then IDLE.
- Registered outputs: addr, dout and wen are registered. wen is never high outside FILL.
- Latency: accept at edge T, SETUP during the cycle after T, first write asserted in the cycle after SETUP ends (wen visible to the BRAM at edge T+2).
- Write count and order: exactly (x1-x0+1)*(y1-y0+1) writes after clamping, each address written once, strictly increasing in raster order. No multiplier is used in FILL.
- Width rules: row_base and addr are ADDR_W bits. The maximum address is H_RES*V_RES-1 = 307199, so no wrap occurs.
- Throughput: back-to-back commands are separated by at least one IDLE cycle (DONE -> IDLE -> accept).

Test Plan:
- Reset: assert reset for 2 cycles mid-FILL -> next cycle wen=0, busy=0, cmd_ready=1, no done pulse.
- Single pixel: x0=x1=5, y0=y1=2, colour 6'b110000 -> exactly one write, addr=1285, dout=0x30; done pulses 1 cycle after the write.
- 3x2 rectangle at (10,5)-(12,6), colour 0x0F -> 6 consecutive writes at addr 3210, 3211, 3212, 3850, 3851, 3852; first wen at edge T+2.
- Clamp: (630,470)-(1000,900) -> writes rows 470..479, cols 630..639; 100 writes; last addr 307199; err=0.
- Reject: x0=20, x1=10 -> no wen at all; done=1 and err=1 in the same cycle, 2 cycles after accept. Also x0=700 -> same result.
- Clear plus stall: cmd_clear=1 colour 0x3F; toggle start low for 5 cycles mid-fill -> 307200 writes total, addresses 0..307199 contiguous with none skipped or repeated; wen=0 and addr held during the stall.
